ss_dp_ctrl: RTL and testbench

- Parametrised successor to the 16-bit data-pointer register.
- Generalised in width, step size and depth; adds push/pop/flush operations, occupancy tracking, full/empty status, sticky overflow/underflow errors, and a frame-offset address output.
- Sits in the datapath beside the register file and drives the memory address mux for stack and frame accesses.
- Downward-growing stack: push decrements `dp`, pop increments it.

---
 rtl/ss_dp_ctrl_pkg.sv | 12 +
 rtl/ss_err_flag.sv | 24 ++
 rtl/ss_dp_ctrl.sv | 93 +++++++++
 tb/tb_ss_dp_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ss_dp_ctrl_pkg.sv
// rtl/ss_dp_ctrl_pkg.sv - shared operation encoding for the data-pointer controller
package ss_dp_ctrl_pkg;

   // Stack operation selected by the op input
   typedef enum logic [1:0] {
      OP_HOLD  = 2'b00,
      OP_PUSH  = 2'b01,
      OP_POP   = 2'b10,
      OP_FLUSH = 2'b11
   } op_e;

endpackage

// File: rtl/ss_err_flag.sv
// rtl/ss_err_flag.sv - sticky error flag, set has priority over clear
module ss_err_flag (
   input  logic i_clk,
   input  logic i_resetn,
   input  logic i_set,
   input  logic i_clr,
   output logic o_flag
);

   logic r_flag;

   // Sticky flag: a fresh error in the clearing cycle must not be lost
   always_ff @(posedge i_clk) begin
      if (!i_resetn)
         r_flag <= 1'b0;
      else if (i_set)
         r_flag <= 1'b1;
      else if (i_clr)
         r_flag <= 1'b0;
   end

   assign o_flag = r_flag;

endmodule

// File: rtl/ss_dp_ctrl.sv
// rtl/ss_dp_ctrl.sv - downward-growing stack/frame data-pointer controller
module ss_dp_ctrl
   import ss_dp_ctrl_pkg::*;
#(
   parameter int                 WIDTH = 16,
   parameter logic [WIDTH-1:0]   TOP   = 16'hFFFE,
   parameter int                 DEPTH = 64,
   parameter int                 STEP  = 1,
   parameter int                 OFFW  = 8,
   localparam int                CW    = $clog2(DEPTH+1)
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [1:0]            op,
   input  logic                  en,
   input  logic                  clr_err,
   input  logic [OFFW-1:0]       offset,
   output logic [WIDTH-1:0]      dp,
   output logic [WIDTH-1:0]      dp_off,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   // The empty pointer must leave room for every entry so dp never wraps
   if (64'(TOP) < 64'(DEPTH) * 64'(STEP)) begin : g_top_check
      $error("ss_dp_ctrl: TOP must be >= DEPTH*STEP");
   end

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] r_dp;
   logic [CW-1:0]    r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_ovf_set;
   logic             w_udf_set;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_push    = en && (op == OP_PUSH);
   assign w_pop     = en && (op == OP_POP);
   assign w_flush   = en && (op == OP_FLUSH);
   assign w_ovf_set = w_push && w_full;
   assign w_udf_set = w_pop && w_empty;

   // Pointer and occupancy move together so dp == TOP - count*STEP always holds
   always_ff @(posedge CLK) begin
      if (!reset) begin
         r_dp    <= TOP;
         r_count <= '0;
      end else if (w_flush) begin
         r_dp    <= TOP;
         r_count <= '0;
      end else if (w_push && !w_full) begin
         r_dp    <= r_dp - STEP_W;
         r_count <= r_count + CW'(1);
      end else if (w_pop && !w_empty) begin
         r_dp    <= r_dp + STEP_W;
         r_count <= r_count - CW'(1);
      end
   end

   ss_err_flag u_ovf (
      .i_clk    (CLK),
      .i_resetn (reset),
      .i_set    (w_ovf_set),
      .i_clr    (clr_err),
      .o_flag   (overflow)
   );

   ss_err_flag u_udf (
      .i_clk    (CLK),
      .i_resetn (reset),
      .i_set    (w_udf_set),
      .i_clr    (clr_err),
      .o_flag   (underflow)
   );

   assign dp     = r_dp;
   assign count  = r_count;
   assign empty  = w_empty;
   assign full   = w_full;
   // Frame address wraps silently; offset is sign-extended to pointer width
   assign dp_off = r_dp + WIDTH'($signed(offset));

endmodule

// File: tb/tb_ss_dp_ctrl.sv
// tb/tb_ss_dp_ctrl.sv - randomized self-checking bench for ss_dp_ctrl
module tb_ss_dp_ctrl;

   localparam int              WIDTH = 16;
   localparam logic [15:0]     TOP   = 16'h0100;
   localparam int              DEPTH = 4;
   localparam int              STEP  = 2;
   localparam int              OFFW  = 8;
   localparam int              CW    = $clog2(DEPTH+1);

   localparam logic [1:0] HOLD  = 2'b00;
   localparam logic [1:0] PUSH  = 2'b01;
   localparam logic [1:0] POP   = 2'b10;
   localparam logic [1:0] FLUSH = 2'b11;

   logic              CLK = 1'b0;
   logic              reset;
   logic [1:0]        op;
   logic              en;
   logic              clr_err;
   logic [OFFW-1:0]   offset;
   logic [WIDTH-1:0]  dp;
   logic [WIDTH-1:0]  dp_off;
   logic [CW-1:0]     count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              underflow;

   int checks   = 0;
   int failures = 0;

   int m_cnt = 0;
   bit m_ovf = 1'b0;
   bit m_udf = 1'b0;

   logic [15:0] push_tab [4] = '{16'h00FE, 16'h00FC, 16'h00FA, 16'h00F8};

   always #5 CLK = ~CLK;

   ss_dp_ctrl #(
      .WIDTH (WIDTH),
      .TOP   (TOP),
      .DEPTH (DEPTH),
      .STEP  (STEP),
      .OFFW  (OFFW)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .op        (op),
      .en        (en),
      .clr_err   (clr_err),
      .offset    (offset),
      .dp        (dp),
      .dp_off    (dp_off),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Stack model: occupancy and flags only; pointer derived from TOP - count*STEP
   task automatic model(input logic r, input logic e, input logic [1:0] o, input logic c);
      if (!r) begin
         m_cnt = 0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         if (e) begin
            if (o == PUSH) begin
               if (m_cnt == DEPTH) m_ovf = 1'b1;
               else m_cnt = m_cnt + 1;
            end else if (o == POP) begin
               if (m_cnt == 0) m_udf = 1'b1;
               else m_cnt = m_cnt - 1;
            end else if (o == FLUSH) begin
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic check_all();
      int          exp_dp;
      logic [15:0] exp_off;
      exp_dp  = int'(TOP) - m_cnt * STEP;
      exp_off = 16'(exp_dp + int'($signed(offset)));
      chk("dp",        32'(dp),        32'(16'(exp_dp)));
      chk("count",     32'(count),     32'(m_cnt));
      chk("empty",     32'(empty),     32'(m_cnt == 0));
      chk("full",      32'(full),      32'(m_cnt == DEPTH));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("dp_off",    32'(dp_off),    32'(exp_off));
   endtask

   task automatic cyc(input logic r, input logic e, input logic [1:0] o,
                      input logic c, input logic [7:0] off);
      @(negedge CLK);
      reset   = r;
      en      = e;
      op      = o;
      clr_err = c;
      offset  = off;
      @(posedge CLK);
      model(r, e, o, c);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; op = HOLD; clr_err = 1'b0; offset = '0;

      // Reset for two cycles
      cyc(0, 0, HOLD, 0, 8'h00);
      cyc(0, 0, HOLD, 0, 8'h00);
      chk("rst_dp",    32'(dp),    32'h0100);
      chk("rst_empty", 32'(empty), 32'd1);
      cyc(1, 0, HOLD, 0, 8'h00);

      // Fill, then overflow
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, PUSH, 0, 8'h00);
         chk("push_dp", 32'(dp), 32'(push_tab[i]));
      end
      chk("full_set", 32'(full), 32'd1);
      cyc(1, 1, PUSH, 0, 8'h00);
      chk("ovf_dp",   32'(dp),       32'h00F8);
      chk("ovf_flag", 32'(overflow), 32'd1);

      // Clear in the same cycle as a new overflow: set wins
      cyc(1, 1, PUSH, 1, 8'h00);
      chk("ovf_setwins", 32'(overflow), 32'd1);
      cyc(1, 0, HOLD, 1, 8'h00);
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Underflow from empty, then clear
      cyc(1, 1, FLUSH, 0, 8'h00);
      cyc(1, 1, POP, 0, 8'h00);
      chk("udf_dp",   32'(dp),        32'h0100);
      chk("udf_flag", 32'(underflow), 32'd1);
      cyc(1, 0, HOLD, 1, 8'h00);
      chk("udf_clr", 32'(underflow), 32'd0);

      // Disabled push, then flush with a flag set
      cyc(1, 1, POP, 0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1, 1, PUSH, 0, 8'h00);
      cyc(1, 0, PUSH, 0, 8'h00);
      chk("en0_dp", 32'(dp), 32'h00FA);
      cyc(1, 1, FLUSH, 0, 8'h00);
      chk("flush_dp",  32'(dp),        32'h0100);
      chk("flush_udf", 32'(underflow), 32'd1);

      // Frame offset
      cyc(1, 1, PUSH, 0, 8'h00);
      cyc(1, 1, PUSH, 0, 8'h00);
      cyc(1, 0, HOLD, 0, 8'hFE);
      chk("off_neg", 32'(dp_off), 32'h00FA);
      cyc(1, 0, HOLD, 0, 8'h04);
      chk("off_pos", 32'(dp_off), 32'h0100);

      // Reset overrides a push at count 2
      cyc(0, 1, PUSH, 0, 8'h00);
      chk("rst_push_dp",  32'(dp),    32'h0100);
      chk("rst_push_cnt", 32'(count), 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic       r, e, c;
         logic [1:0] o;
         r = ($urandom_range(0, 49) != 0);
         e = ($urandom_range(0, 7) != 0);
         c = ($urandom_range(0, 9) == 0);
         o = 2'($urandom_range(0, 3));
         if (o == FLUSH && $urandom_range(0, 3) != 0) o = PUSH;
         cyc(r, e, o, c, 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
